// File: rtl/pow2_approx_pipe.sv
// pow2_approx_pipe
// Three-stage, multi-lane approximation of pow = 2^(x - X_MAX) for signed
// fixed-point x. It uses a Mitchell mantissa (1+f), with an optional
// quadratic correction selected per beat. Out-of-range inputs saturate high
// or flush to zero instead of wrapping. All lanes share one valid/ready
// handshake, so the block can sit directly in a backpressured stream.
module pow2_approx_pipe #(
    parameter int LANES     = 1,
    parameter int IN_INT_W  = 6,
    parameter int IN_FRAC_W = 10,
    parameter int OUT_W     = 16,
    parameter int X_MAX     = 5
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   en,
    input  logic                                   valid_in,
    output logic                                   ready_in,
    input  logic                                   mode_in,
    input  logic [LANES*(IN_INT_W+IN_FRAC_W)-1:0]  in_x,
    output logic                                   valid_out,
    input  logic                                   ready_out,
    output logic [LANES*OUT_W-1:0]                 pow_out,
    output logic [LANES*(IN_INT_W+IN_FRAC_W)-1:0]  x_bypass,
    output logic [LANES-1:0]                       ovf_out,
    output logic [LANES-1:0]                       unf_out
);

    // Width of one input lane.
    localparam int IN_W = IN_INT_W + IN_FRAC_W;
    // Width of the signed shift distance d = X_MAX - int.
    localparam int D_W  = IN_INT_W + 1;
    // Width of the mantissa, Q1.IN_FRAC_W.
    localparam int M_W  = IN_FRAC_W + 1;
    // Width that holds f * (2^F - f) without loss.
    localparam int P_W  = 2 * IN_FRAC_W + 2;
    // Left shift that places the mantissa's leading one at the output MSB.
    localparam int SH   = OUT_W - 1 - IN_FRAC_W;

    localparam logic signed [D_W-1:0] X_MAX_D = D_W'(X_MAX);

    logic advance;
    logic accept;
    logic load_s2;
    logic load_s3;
    logic s1_valid;
    logic s1_mode;
    logic s2_valid;

    // The whole pipe moves as one unit. It advances only when enabled and
    // when the output slot is empty or is being consumed this cycle.
    assign advance  = en && (!valid_out || ready_out);
    assign ready_in = advance;
    assign accept   = valid_in && advance;
    assign load_s2  = advance && s1_valid;
    assign load_s3  = advance && s2_valid;

    // Stage valid bits and the shared mode bit. Bubbles travel through the
    // pipe like ordinary beats; they are not squeezed out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_mode   <= 1'b0;
            s2_valid  <= 1'b0;
            valid_out <= 1'b0;
        end else if (advance) begin
            s1_valid  <= valid_in;
            if (valid_in) begin
                s1_mode <= mode_in;
            end
            s2_valid  <= s1_valid;
            valid_out <= s2_valid;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane

        // ---------------- stage 1: split x and classify range ----------------
        logic [IN_W-1:0]            x_k;
        logic signed [IN_INT_W-1:0] int_k;
        logic signed [D_W-1:0]      d_k;
        logic                       ovf_k;
        logic                       unf_k;

        assign x_k   = in_x[k*IN_W +: IN_W];
        assign int_k = x_k[IN_W-1 -: IN_INT_W];
        assign d_k   = X_MAX_D - {int_k[IN_INT_W-1], int_k};
        assign ovf_k = d_k[D_W-1];
        assign unf_k = !d_k[D_W-1] && ({{(32-D_W){1'b0}}, d_k} >= 32'(OUT_W));

        logic signed [D_W-1:0]  s1_d;
        logic [IN_FRAC_W-1:0]   s1_f;
        logic                   s1_ovf;
        logic                   s1_unf;
        logic [IN_W-1:0]        s1_x;

        // Capture the shift distance, fraction and range flags of an accepted beat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_d   <= '0;
                s1_f   <= '0;
                s1_ovf <= 1'b0;
                s1_unf <= 1'b0;
                s1_x   <= '0;
            end else if (accept) begin
                s1_d   <= d_k;
                s1_f   <= x_k[IN_FRAC_W-1:0];
                s1_ovf <= ovf_k;
                s1_unf <= unf_k;
                s1_x   <= x_k;
            end
        end

        // ---------------- stage 2: build the mantissa ----------------
        logic [M_W-1:0]       m_plain;
        logic [IN_FRAC_W:0]   comp;
        logic [P_W-1:0]       prod;
        logic [IN_FRAC_W-1:0] p;
        logic [IN_FRAC_W-1:0] corr;
        logic [M_W-1:0]       m_k;

        // The correction term approximates 0.34375 * f * (1 - f). That is
        // always smaller than f, so the corrected mantissa never drops below 1.0.
        assign m_plain = {1'b1, s1_f};
        assign comp    = {1'b1, {IN_FRAC_W{1'b0}}} - {1'b0, s1_f};
        assign prod    = P_W'(s1_f) * P_W'(comp);
        assign p       = IN_FRAC_W'(prod >> IN_FRAC_W);
        assign corr    = (p >> 2) + (p >> 4) + (p >> 5);
        assign m_k     = s1_mode ? (m_plain - M_W'(corr)) : m_plain;

        logic [M_W-1:0]         s2_m;
        logic signed [D_W-1:0]  s2_d;
        logic                   s2_ovf;
        logic                   s2_unf;
        logic [IN_W-1:0]        s2_x;

        // Register the mantissa and carry the shift distance and flags along with it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_m   <= '0;
                s2_d   <= '0;
                s2_ovf <= 1'b0;
                s2_unf <= 1'b0;
                s2_x   <= '0;
            end else if (load_s2) begin
                s2_m   <= m_k;
                s2_d   <= s1_d;
                s2_ovf <= s1_ovf;
                s2_unf <= s1_unf;
                s2_x   <= s1_x;
            end
        end

        // ---------------- stage 3: scale, saturate, flush ----------------
        logic [OUT_W-1:0] w_k;
        logic [OUT_W-1:0] pow_k;

        // A negative d only occurs together with ovf, which overrides the
        // shift. Treating d as unsigned in the shift is therefore harmless.
        assign w_k   = OUT_W'(s2_m) << SH;
        assign pow_k = s2_ovf ? '1 : (s2_unf ? '0 : (w_k >> s2_d));

        logic [OUT_W-1:0] pow_q;
        logic             ovf_q;
        logic             unf_q;
        logic [IN_W-1:0]  x_q;

        // Output registers. They keep the last real result across bubbles and stalls.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pow_q <= '0;
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
                x_q   <= '0;
            end else if (load_s3) begin
                pow_q <= pow_k;
                ovf_q <= s2_ovf;
                unf_q <= s2_unf;
                x_q   <= s2_x;
            end
        end

        assign pow_out[k*OUT_W +: OUT_W] = pow_q;
        assign x_bypass[k*IN_W +: IN_W]  = x_q;
        assign ovf_out[k]                = ovf_q;
        assign unf_out[k]                = unf_q;
    end

endmodule

// File: tb/tb_pow2_approx_pipe.sv
// tb_pow2_approx_pipe
// Bench with two instances: a default-parameter pipe exercised through a
// table of known vectors and hand-written corner sequences, and a 4-lane,
// 24-bit pipe driven with random traffic and checked against a plain
// arithmetic model of 2^(x - X_MAX).
module tb_pow2_approx_pipe;

    logic clk = 1'b0;
    logic rst_n;

    // Clock with a 10 ns period.
    always #5 clk = ~clk;

    // Signals for the default instance.
    logic        en, valid_in, ready_in, mode_in, valid_out, ready_out;
    logic [15:0] in_x, pow_out, x_bypass;
    logic [0:0]  ovf_out, unf_out;

    // Signals for the wide instance.
    logic        w_en, w_valid_in, w_ready_in, w_mode_in, w_valid_out, w_ready_out;
    logic [71:0] w_in_x, w_x_bypass;
    logic [95:0] w_pow_out;
    logic [3:0]  w_ovf_out, w_unf_out;

    pow2_approx_pipe dut (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_in(valid_in), .ready_in(ready_in),
        .mode_in(mode_in), .in_x(in_x), .valid_out(valid_out), .ready_out(ready_out),
        .pow_out(pow_out), .x_bypass(x_bypass), .ovf_out(ovf_out), .unf_out(unf_out)
    );

    pow2_approx_pipe #(.LANES(4), .IN_INT_W(6), .IN_FRAC_W(12), .OUT_W(24), .X_MAX(5)) dut_wide (
        .clk(clk), .rst_n(rst_n), .en(w_en), .valid_in(w_valid_in), .ready_in(w_ready_in),
        .mode_in(w_mode_in), .in_x(w_in_x), .valid_out(w_valid_out), .ready_out(w_ready_out),
        .pow_out(w_pow_out), .x_bypass(w_x_bypass), .ovf_out(w_ovf_out), .unf_out(w_unf_out)
    );

    typedef struct {
        logic [15:0] x;
        logic        mode;
        logic [15:0] pow;
        logic        ovf;
        logic        unf;
    } vec_t;

    typedef struct {
        logic [15:0] pow;
        logic        ovf;
        logic        unf;
        logic [15:0] x;
    } exp_t;

    typedef struct {
        logic [95:0] pow;
        logic [3:0]  ovf;
        logic [3:0]  unf;
        logic [71:0] x;
    } exp4_t;

    exp_t  expQ[$];
    exp4_t expWQ[$];
    int    checks = 0;
    int    passes = 0;
    int    beatNo = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act == req) passes++;
        else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    endtask

    // Reference: pow = floor((1+f_corr) * 2^(OUT_W-1) / 2^d), evaluated on
    // the real integer value of x, with saturation and flush outside the range.
    function automatic void refLane(input longint raw, input int intW, input int fracW,
                                    input int outW, input int xMax, input bit mode,
                                    output longint pow, output bit ovf, output bit unf);
        longint inW, one, xs, ip, f, d, m, p;
        inW = intW + fracW;
        one = longint'(1) << fracW;
        xs  = raw;
        if (xs >= (longint'(1) << (inW - 1))) xs -= (longint'(1) << inW);
        ip  = (xs >= 0) ? xs / one : -((-xs + one - 1) / one);
        f   = xs - ip * one;
        d   = xMax - ip;
        ovf = 1'b0;
        unf = 1'b0;
        pow = 0;
        if (d < 0) begin
            ovf = 1'b1;
            pow = (longint'(1) << outW) - 1;
        end else if (d >= outW) begin
            unf = 1'b1;
        end else begin
            m = one + f;
            if (mode) begin
                p = (f * (one - f)) / one;
                m = m - (p / 4 + p / 16 + p / 32);
            end
            pow = (m * (longint'(1) << (outW - 1 - fracW))) / (longint'(1) << d);
        end
    endfunction

    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            check("spurious valid_out", longint'(valid_out), 0);
        end else begin
            e = expQ.pop_front();
            beatNo++;
            check($sformatf("beat%0d pow (x=%h)", beatNo, e.x), pow_out, e.pow);
            check($sformatf("beat%0d ovf (x=%h)", beatNo, e.x), ovf_out, e.ovf);
            check($sformatf("beat%0d unf (x=%h)", beatNo, e.x), unf_out, e.unf);
            check($sformatf("beat%0d x_bypass", beatNo), x_bypass, e.x);
        end
    endtask

    // One cycle on the default instance: drive at negedge, score the handshake, advance.
    task automatic applyStimulus(input bit vin, input logic [15:0] x, input bit mode,
                                 input bit e, input bit rdy, input logic [15:0] epow,
                                 input bit eovf, input bit eunf, output bit acc);
        valid_in  = vin;
        in_x      = x;
        mode_in   = mode;
        en        = e;
        ready_out = rdy;
        #1;
        if (valid_out && ready_out && en) checkOutput();
        acc = vin && ready_in && rst_n;
        if (acc) expQ.push_back('{epow, eovf, eunf, x});
        @(negedge clk);
    endtask

    task automatic sendBeat(input logic [15:0] x, input bit mode, input logic [15:0] epow,
                            input bit eovf, input bit eunf);
        bit acc = 1'b0;
        for (int t = 0; t < 30 && !acc; t++) applyStimulus(1'b1, x, mode, 1'b1, 1'b1, epow, eovf, eunf, acc);
        if (!acc) check("accept timeout", longint'(ready_in), 1);
    endtask

    task automatic sendModel(input logic [15:0] x, input bit mode);
        longint p;
        bit o, u;
        refLane(longint'(x), 6, 10, 16, 5, mode, p, o, u);
        sendBeat(x, mode, 16'(p), o, u);
    endtask

    task automatic drain();
        bit acc;
        for (int t = 0; t < 40 && expQ.size() > 0; t++)
            applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0, acc);
        check("default drain leftover beats", expQ.size(), 0);
    endtask

    task automatic modelWide(input logic [71:0] x, input bit mode, output exp4_t e);
        longint p;
        bit o, u;
        for (int l = 0; l < 4; l++) begin
            refLane(longint'(x[l*18 +: 18]), 6, 12, 24, 5, mode, p, o, u);
            e.pow[l*24 +: 24] = 24'(p);
            e.ovf[l] = o;
            e.unf[l] = u;
        end
        e.x = x;
    endtask

    task automatic checkOutputWide();
        exp4_t e;
        if (expWQ.size() == 0) begin
            check("wide spurious valid_out", longint'(w_valid_out), 0);
        end else begin
            e = expWQ.pop_front();
            beatNo++;
            for (int l = 0; l < 4; l++) begin
                check($sformatf("wide beat%0d lane%0d pow", beatNo, l), w_pow_out[l*24 +: 24], e.pow[l*24 +: 24]);
                check($sformatf("wide beat%0d lane%0d ovf", beatNo, l), w_ovf_out[l], e.ovf[l]);
                check($sformatf("wide beat%0d lane%0d unf", beatNo, l), w_unf_out[l], e.unf[l]);
                check($sformatf("wide beat%0d lane%0d x", beatNo, l), w_x_bypass[l*18 +: 18], e.x[l*18 +: 18]);
            end
        end
    endtask

    task automatic applyStimulusWide(input bit vin, input logic [71:0] x, input bit mode,
                                     input bit e, input bit rdy, input exp4_t ex, output bit acc);
        w_valid_in  = vin;
        w_in_x      = x;
        w_mode_in   = mode;
        w_en        = e;
        w_ready_out = rdy;
        #1;
        if (w_valid_out && w_ready_out && w_en) checkOutputWide();
        acc = vin && w_ready_in && rst_n;
        if (acc) expWQ.push_back(ex);
        @(negedge clk);
    endtask

    vec_t        tbl[$];
    bit          acc, pend, pm;
    logic [15:0] px, heldPow, snapPow, snapX;
    logic        snapValid;
    longint      p;
    bit          o, u;
    int          idx, stall;
    logic [15:0] bpX[6];
    bit          bpM[6];
    logic [71:0] wx;
    exp4_t       we;

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired: passed=%0d required=%0d", passes, checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en = 1'b1; valid_in = 1'b0; mode_in = 1'b0; in_x = '0; ready_out = 1'b1;
        w_en = 1'b1; w_valid_in = 1'b0; w_mode_in = 1'b0; w_in_x = '0; w_ready_out = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("reset valid_out", valid_out, 0);
        check("reset pow_out", pow_out, 0);
        check("reset x_bypass", x_bypass, 0);
        check("reset ovf/unf", {ovf_out, unf_out}, 0);
        check("reset wide valid_out", w_valid_out, 0);
        check("reset wide pow zero", longint'(w_pow_out == '0), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency: 5.0 appears exactly three cycles after acceptance
        applyStimulus(1'b1, 16'h1400, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b0, acc);
        check("first beat accepted", acc, 1);
        check("latency cycle1 valid_out", valid_out, 0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0, acc);
        check("latency cycle2 valid_out", valid_out, 0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0, acc);
        check("latency cycle3 valid_out", valid_out, 1);
        drain();

        // Known vectors, back to back, including alternating modes and range edges
        tbl.push_back('{16'h1400, 1'b0, 16'h8000, 1'b0, 1'b0});
        tbl.push_back('{16'h1400, 1'b1, 16'h8000, 1'b0, 1'b0});
        tbl.push_back('{16'h0000, 1'b0, 16'h0400, 1'b0, 1'b0});
        tbl.push_back('{16'hD800, 1'b0, 16'h0001, 1'b0, 1'b0});
        tbl.push_back('{16'h1000, 1'b0, 16'h4000, 1'b0, 1'b0});
        tbl.push_back('{16'hFC00, 1'b0, 16'h0200, 1'b0, 1'b0});
        tbl.push_back('{16'hFE00, 1'b0, 16'h0300, 1'b0, 1'b0});
        tbl.push_back('{16'h0200, 1'b0, 16'h0600, 1'b0, 1'b0});
        tbl.push_back('{16'h0200, 1'b1, 16'h05A8, 1'b0, 1'b0});
        tbl.push_back('{16'h1200, 1'b0, 16'h6000, 1'b0, 1'b0});
        tbl.push_back('{16'h1200, 1'b1, 16'h5A80, 1'b0, 1'b0});
        tbl.push_back('{16'h1200, 1'b0, 16'h6000, 1'b0, 1'b0});
        tbl.push_back('{16'h1200, 1'b1, 16'h5A80, 1'b0, 1'b0});
        tbl.push_back('{16'h1800, 1'b0, 16'hFFFF, 1'b1, 1'b0});
        tbl.push_back('{16'h1800, 1'b1, 16'hFFFF, 1'b1, 1'b0});
        tbl.push_back('{16'hD400, 1'b0, 16'h0000, 1'b0, 1'b1});
        tbl.push_back('{16'hD7FF, 1'b0, 16'h0000, 1'b0, 1'b1});
        tbl.push_back('{16'h7FFF, 1'b0, 16'hFFFF, 1'b1, 1'b0});
        tbl.push_back('{16'h8000, 1'b0, 16'h0000, 1'b0, 1'b1});
        foreach (tbl[i]) sendBeat(tbl[i].x, tbl[i].mode, tbl[i].pow, tbl[i].ovf, tbl[i].unf);
        drain();

        // Backpressure: 6 beats, ready_out low for 4 cycles after the first valid_out
        bpX = '{16'h1400, 16'h1200, 16'h0000, 16'h1200, 16'hD800, 16'h1800};
        bpM = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        idx = 0;
        stall = -1;
        heldPow = '0;
        for (int cyc = 0; cyc < 60 && (idx < 6 || expQ.size() > 0); cyc++) begin
            if (stall < 0 && valid_out) begin
                stall = 0;
                heldPow = pow_out;
            end
            px = (idx < 6) ? bpX[idx] : 16'h0;
            pm = (idx < 6) ? bpM[idx] : 1'b0;
            refLane(longint'(px), 6, 10, 16, 5, pm, p, o, u);
            applyStimulus(idx < 6, px, pm, 1'b1, !(stall >= 0 && stall < 4), 16'(p), o, u, acc);
            if (acc) idx++;
            if (stall >= 0 && stall < 4) begin
                check($sformatf("stall%0d ready_in", stall), ready_in, 0);
                check($sformatf("stall%0d pow_out held", stall), pow_out, heldPow);
            end
            if (stall >= 0) stall++;
        end
        check("backpressure beats accepted", idx, 6);
        check("backpressure leftover beats", expQ.size(), 0);

        // en low for two cycles mid-stream freezes everything
        sendModel(16'h1200, 1'b1);
        sendModel(16'h0400, 1'b0);
        sendModel(16'hE000, 1'b1);
        snapValid = valid_out;
        snapPow   = pow_out;
        snapX     = x_bypass;
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b1, 16'h0C00, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, acc);
            check($sformatf("en-low%0d ready_in", c), ready_in, 0);
            check($sformatf("en-low%0d valid_out", c), valid_out, snapValid);
            check($sformatf("en-low%0d pow_out", c), pow_out, snapPow);
            check($sformatf("en-low%0d x_bypass", c), x_bypass, snapX);
        end
        sendModel(16'h0C00, 1'b0);
        sendModel(16'hF600, 1'b1);
        drain();

        // Asynchronous reset mid-stream drops everything in flight
        sendModel(16'h1200, 1'b0);
        sendModel(16'h0A00, 1'b1);
        sendModel(16'h1000, 1'b0);
        valid_in = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("async reset valid_out", valid_out, 0);
        check("async reset pow_out", pow_out, 0);
        check("async reset x_bypass", x_bypass, 0);
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0, acc);
            check($sformatf("post-reset%0d valid_out", c), valid_out, 0);
            check($sformatf("post-reset%0d pow_out", c), pow_out, 0);
        end
        sendModel(16'h0000, 1'b0);
        drain();

        // Random traffic on the default instance
        pend = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (!pend && $urandom_range(0, 99) < 75) begin
                pend = 1'b1;
                px = 16'($urandom_range(0, 65535));
                pm = 1'($urandom_range(0, 1));
                refLane(longint'(px), 6, 10, 16, 5, pm, p, o, u);
            end
            applyStimulus(pend, px, pm, $urandom_range(0, 99) < 90, $urandom_range(0, 99) < 70,
                          16'(p), o, u, acc);
            if (acc) pend = 1'b0;
        end
        drain();

        // Wide instance: a directed beat at the range edges, then random traffic
        wx = {18'h2E000, 18'h05000, 18'h2D000, 18'h06000};
        modelWide(wx, 1'b0, we);
        acc = 1'b0;
        for (int t = 0; t < 30 && !acc; t++) applyStimulusWide(1'b1, wx, 1'b0, 1'b1, 1'b1, we, acc);
        check("wide directed accepted", acc, 1);
        pend = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (!pend && $urandom_range(0, 99) < 80) begin
                pend = 1'b1;
                for (int l = 0; l < 4; l++) wx[l*18 +: 18] = 18'($urandom_range(0, 262143));
                pm = 1'($urandom_range(0, 1));
                modelWide(wx, pm, we);
            end
            applyStimulusWide(pend, wx, pm, $urandom_range(0, 99) < 90, $urandom_range(0, 99) < 70,
                              we, acc);
            if (acc) pend = 1'b0;
        end
        for (int t = 0; t < 40 && expWQ.size() > 0; t++)
            applyStimulusWide(1'b0, 72'h0, 1'b0, 1'b1, 1'b1, we, acc);
        check("wide drain leftover beats", expWQ.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pow2_approx_pipe.md
Name: pow2_approx_pipe

Overview:
- Parametrised, multi-lane successor of the stage-3 power-of-two approximation.
- Computes pow_out ≈ 2^(x − X_MAX) for signed fixed-point x.
- Mitchell mantissa (1+f) with an optional quadratic correction selected per transaction.
- Saturates instead of wrapping, flags overflow/underflow, and supports valid/ready backpressure so it can sit between softmax stage 2 (max-subtract) and the accumulator tree.

Parameters:
- LANES, 1, parallel lanes sharing one handshake.
- IN_INT_W, 6, signed integer bits of x (two's complement).
- IN_FRAC_W, 10, fractional bits of x.
- OUT_W, 16, output width, unsigned Q1.(OUT_W−1); OUT_W−1 ≥ IN_FRAC_W required.
- X_MAX, 5, integer exponent mapped to 1.0.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, global enable; low freezes all registers and forces ready_in=0.
- valid_in, input, 1, input beat valid.
- ready_in, output, 1, block accepts a beat this cycle.
- mode_in, input, 1, 0 = plain (1+f), 1 = corrected mantissa; sampled with the beat.
- in_x, input, LANES*(IN_INT_W+IN_FRAC_W), lane k in bits [k*IN_W +: IN_W].
- valid_out, output, 1, output beat valid.
- ready_out, input, 1, downstream accepts.
- pow_out, output, LANES*OUT_W, per-lane result.
- x_bypass, output, LANES*IN_W, in_x delayed to align with pow_out.
- ovf_out, output, LANES, lane saturated high.
- unf_out, output, LANES, lane flushed to zero.

Behaviour:
- Reset (async assert, sync-clocked release): all stage valids = 0; pow_out, x_bypass, ovf_out, unf_out = 0; valid_out = 0.
- Pipeline: 3 stages, latency 3 cycles from accepted beat to valid_out when not stalled.
- advance = en && (!valid_out || ready_out). ready_in = advance.
- All stages move together when advance=1 and hold otherwise. Bubbles are not collapsed.
- A beat is accepted when valid_in && ready_in.
- S1: per lane, split int/frac and compute d = X_MAX − int as signed, IN_INT_W+1 bits.
  - d < 0 → ovf.
  - d ≥ OUT_W → unf.
  - Register d, f, flags, mode, and x.
- S2: m = 2^IN_FRAC_W + f (Q1.IN_FRAC_W).
  - If mode=1: p = (f*(2^IN_FRAC_W − f)) >> IN_FRAC_W (truncate); corr = (p>>2)+(p>>4)+(p>>5); m = m − corr.
  - corr never exceeds f, so no underflow.
- S3: w = m << (OUT_W−1−IN_FRAC_W); pow = w >> d, truncating.
  - ovf → pow = all ones.
  - unf → pow = 0.
  - Flags are registered alongside pow.
- Lanes are independent arithmetically. Handshake and mode are shared.
- Output holds stable while valid_out && !ready_out.
- valid_in with en=0: not accepted. Upstream must hold the beat.
- rst_n asserted mid-stream drops all in-flight beats with no partial outputs.
- With defaults, legacy results match for int ∈ [−10,5] in mode 0.
- int > X_MAX now saturates; the legacy behaviour returned 0.

Test Plan:
- Defaults, LANES=1, mode 0, ready_out=1.
  - x=0x1400 (5.0) → pow=0x8000, 3 cycles after acceptance.
  - x=0x0000 → pow=0x0400.
  - x=0xD800 (−10.0) → pow=0x0001, unf=0.
- x=0x1200 (4.5).
  - mode 0 → pow=0x6000.
  - mode 1 → pow=0x5A80 (ideal 0x5A82).
  - Back-to-back beats alternating mode produce both values in order.
- Boundary handling.
  - x=0x1800 (6.0) → pow=0xFFFF, ovf=1.
  - x=0xD400 (−11.0) → pow=0, unf=1.
  - x=0x7FFF → ovf=1.
  - x=0x8000 → unf=1.
- Backpressure: stream 6 beats, hold ready_out=0 for 4 cycles after the first valid_out.
  - ready_in=0 during the stall and pow_out stable.
  - No beat lost or duplicated.
  - x_bypass matches each input.
- en=0 for 2 cycles mid-stream freezes state.
  - Assert rst_n=0 asynchronously mid-stream → valid_out=0 immediately.
  - After release, outputs stay 0 until new beats are accepted.
- LANES=4, OUT_W=24, IN_FRAC_W=12: randomised x against a reference model.
  - Per-lane pow, ovf, and unf bit-exact.
